// File: rtl/paddle_tracker.sv
// Quadrature-encoder paddle tracker: per-channel sync, edge decode and saturating position.
// Optional input debounce filter is compiled in with `define PADDLE_DEBOUNCE_EN.
`timescale 1ns/1ps
module paddle_tracker #(
  parameter int NUM_PADDLES = 2,
  parameter int POS_W       = 6,
  parameter int PADDLE_H    = 8,
  parameter int Y_INIT      = 28,
  parameter int DEB_CYCLES  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PADDLES-1:0]         enc_a,
  input  logic [NUM_PADDLES-1:0]         enc_b,
  input  logic                           reset_game,
  output logic [NUM_PADDLES*POS_W-1:0]   py,
  output logic [NUM_PADDLES-1:0]         moved,
  output logic [NUM_PADDLES-1:0]         enc_err
);

  localparam int NB = 2 * NUM_PADDLES;
  localparam logic [POS_W:0]   MAX_POS  = (POS_W+1)'((1 << POS_W) - PADDLE_H);
  localparam logic [POS_W-1:0] Y_INIT_P = POS_W'(Y_INIT);

  if (NUM_PADDLES < 1 || NUM_PADDLES > 8) begin : g_bad_num_paddles
    $error("paddle_tracker: NUM_PADDLES must be 1..8");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("paddle_tracker: DEB_CYCLES must be at least 1");
  end

  // Bit i is channel i's A, bit NUM_PADDLES+i is channel i's B.
  logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, cur_ab;
  logic [NUM_PADDLES-1:0][POS_W-1:0] py_q, py_d;
  logic [NUM_PADDLES-1:0][POS_W:0]   pos_up, pos_dn;
  logic [NUM_PADDLES-1:0][1:0]       pair_prev, pair_cur;
  logic [NUM_PADDLES-1:0]            moved_q, moved_d, err_q, err_d;

  always_comb begin
    sync1_d = {enc_b, enc_a};
    sync2_d = sync1_q;
  end

`ifdef PADDLE_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [NB-1:0]            deb_q, deb_d;
  logic [NB-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // A new level is taken only after DEB_CYCLES consecutive cycles of disagreement.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign cur_ab = deb_q;
`else
  assign cur_ab = sync2_q;
`endif

  always_comb begin
    prev_d    = cur_ab;
    py_d      = py_q;
    moved_d   = '0;
    err_d     = err_q;
    pos_up    = '0;
    pos_dn    = '0;
    pair_prev = '0;
    pair_cur  = '0;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      pair_prev[i] = {prev_q[i], prev_q[NUM_PADDLES+i]};
      pair_cur[i]  = {cur_ab[i], cur_ab[NUM_PADDLES+i]};
      // One extra bit: overflow past MAX_POS or borrow below 0 is visible, never wrapped.
      pos_up[i] = {1'b0, py_q[i]} + 1'b1;
      pos_dn[i] = {1'b0, py_q[i]} - 1'b1;
      if (reset_game) begin
        py_d[i]  = Y_INIT_P;
        err_d[i] = 1'b0;
      end else if ((pair_prev[i] ^ pair_cur[i]) == 2'b11) begin
        err_d[i] = 1'b1;
      end else if (pair_prev[i] == 2'b00 && pair_cur[i] == 2'b10) begin
        if (pos_up[i] <= MAX_POS) begin
          py_d[i]    = pos_up[i][POS_W-1:0];
          moved_d[i] = 1'b1;
        end
      end else if (pair_prev[i] == 2'b00 && pair_cur[i] == 2'b01) begin
        if (!pos_dn[i][POS_W]) begin
          py_d[i]    = pos_dn[i][POS_W-1:0];
          moved_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      py_q    <= {NUM_PADDLES{Y_INIT_P}};
      moved_q <= '0;
      err_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      py_q    <= py_d;
      moved_q <= moved_d;
      err_q   <= err_d;
    end
  end

  assign py      = py_q;
  assign moved   = moved_q;
  assign enc_err = err_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed scoreboard bench for paddle_tracker: expected positions are queued per
// channel at stimulus time and popped by a monitor whenever moved pulses.
`timescale 1ns/1ps
module tb_paddle_tracker;

  localparam int NP  = 2;
  localparam int PW  = 6;
  localparam int PH  = 8;
  localparam int YI  = 28;
  localparam int DEB = 4;
`ifdef PADDLE_DEBOUNCE_EN
  localparam int EXTRA = DEB;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT  = 3 + EXTRA;
  localparam int HOLD = 2 + EXTRA;

  // clock / reset block
  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0] enc_a, enc_b;
  logic reset_game;
  logic [NP*PW-1:0] py;
  logic [NP-1:0] moved, enc_err;

  always #5 clk = ~clk;

  paddle_tracker #(
    .NUM_PADDLES(NP), .POS_W(PW), .PADDLE_H(PH), .Y_INIT(YI), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .reset_game(reset_game), .py(py), .moved(moved), .enc_err(enc_err)
  );

  // scoreboard
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [PW-1:0] py_of(input int ch);
    return py[ch*PW +: PW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic mon_pop(input int ch, input logic [PW-1:0] act);
    logic [PW-1:0] e;
    tests_run++;
    if (ch == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
    else if (ch == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    else begin
      tests_failed++;
      $display("FAIL mon_unexpected_move ch%0d: got moved with py=%0d, required no move", ch, act);
      return;
    end
    if (act !== e) begin
      tests_failed++;
      $display("FAIL mon_py ch%0d: got %0d, required %0d", ch, act, e);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      if (moved[0]) mon_pop(0, py_of(0));
      if (moved[1]) mon_pop(1, py_of(1));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NP-1:0] a, input logic [NP-1:0] b);
    enc_a = a;
    enc_b = b;
    tick(HOLD);
    enc_a = '0;
    enc_b = '0;
    tick(HOLD);
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  endtask

  initial begin
    #2000000;
    tests_failed++;
    $display("FAIL watchdog: got timeout, required normal completion");
    finish_run();
  end

  initial begin
    reset = 1'b0;
    enc_a = '0;
    enc_b = '0;
    reset_game = 1'b0;
    tick(3);
    check("reset_py0", py_of(0), YI);
    check("reset_py1", py_of(1), YI);
    check("reset_moved", moved, 0);
    check("reset_err", enc_err, 0);
    reset = 1'b1;
    tick(2);

    // single increment: latency and one moved pulse
    exp_q0.push_back(6'd29);
    enc_a[0] = 1'b1;
    tick(LAT - 1);
    check("lat_before_py0", py_of(0), 28);
    tick(1);
    check("lat_after_py0", py_of(0), 29);
    check("lat_moved", moved, 2'b01);
    tick(1);
    check("lat_moved_cleared", moved, 0);
    enc_a = '0;
    tick(HOLD + 2);

    // saturation at the top on ch1
    for (int k = 1; k <= 40; k++) begin
      if (28 + k <= 56) exp_q1.push_back(PW'(28 + k));
      pulse(2'b10, 2'b00);
    end
    check("sat_py1", py_of(1), 56);
    check("sat_q1_drained", exp_q1.size(), 0);
    check("sat_py0_untouched", py_of(0), 29);

    // walk ch0 down to 0
    for (int k = 1; k <= 29; k++) begin
      exp_q0.push_back(PW'(29 - k));
      pulse(2'b00, 2'b01);
    end
    check("floor_py0", py_of(0), 0);
    exp_q1.push_back(6'd55);
    pulse(2'b00, 2'b10);
    check("dec_py1", py_of(1), 55);

    // ch0 decrement rejected at 0 while ch1 increments in the same cycle
    exp_q1.push_back(6'd56);
    enc_a = 2'b10;
    enc_b = 2'b01;
    tick(LAT);
    check("simul_moved", moved, 2'b10);
    check("simul_py0", py_of(0), 0);
    check("simul_py1", py_of(1), 56);
    enc_a = '0;
    enc_b = '0;
    tick(HOLD + 2);
    check("simul_py0_hold", py_of(0), 0);

    // illegal two-bit change then recentre
    enc_a = 2'b01;
    enc_b = 2'b01;
    tick(LAT);
    check("illegal_err", enc_err, 2'b01);
    check("illegal_py0", py_of(0), 0);
    enc_a = '0;
    enc_b = '0;
    tick(HOLD + LAT);
    check("illegal_err_sticky", enc_err, 2'b01);
    reset_game = 1'b1;
    tick(1);
    check("rg_err", enc_err, 0);
    check("rg_py0", py_of(0), 28);
    check("rg_py1", py_of(1), 28);
    check("rg_moved", moved, 0);
    reset_game = 1'b0;
    tick(2);

    // recentre collides with a decoded increment
    enc_a[0] = 1'b1;
    tick(LAT - 1);
    reset_game = 1'b1;
    tick(1);
    check("rg_collide_py0", py_of(0), 28);
    check("rg_collide_moved", moved, 0);
    reset_game = 1'b0;
    tick(HOLD + 2);
    check("rg_resume_py0", py_of(0), 28);
    enc_a = '0;
    tick(HOLD + 1);

    // reset mid-movement
    enc_a[1] = 1'b1;
    tick(1);
    reset = 1'b0;
    enc_a = '0;
    tick(2);
    check("midreset_py1", py_of(1), 28);
    check("midreset_moved", moved, 0);
    reset = 1'b1;
    tick(LAT + HOLD);
    check("postreset_py0", py_of(0), 28);
    check("postreset_py1", py_of(1), 28);

`ifdef PADDLE_DEBOUNCE_EN
    // short glitch ignored, long pulse gives exactly one step
    enc_a[0] = 1'b1;
    tick(2);
    enc_a = '0;
    tick(12);
    check("deb_glitch_py0", py_of(0), 28);
    exp_q0.push_back(6'd29);
    enc_a[0] = 1'b1;
    tick(6);
    enc_a = '0;
    tick(12);
    check("deb_step_py0", py_of(0), 29);
`endif

    check("final_q0_drained", exp_q0.size(), 0);
    check("final_q1_drained", exp_q1.size(), 0);
    finish_run();
  end

endmodule
